// File: rtl/exec_ctrl.sv
// Execution controller for a single-cycle CPU. It provides run, pause, single-step
// and halt control, a synchronized go button, retirement counters and a display mux.
module exec_ctrl #(
    parameter logic [31:0] HALT_CODE = 32'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        step_mode,
    input  logic        syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    input  logic        jmp_taken,
    input  logic        br_taken,
    input  logic [1:0]  disp_sel,
    output logic        pc_enable,
    output logic        halted,
    output logic [31:0] disp_data
);

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_PAUSE     = 3'd1,
        S_STEP_WAIT = 3'd2,
        S_RESUME    = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        go_meta;
    logic        go_sync;
    logic        go_prev;
    logic        go_pulse;
    logic        retire;
    logic        latch_sys;
    logic [31:0] sys_reg;
    logic [31:0] cycle_cnt;
    logic [15:0] jmp_cnt;
    logic [15:0] br_cnt;

    // The raw button passes through two synchronizer flops, then a rising-edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            go_meta <= 1'b0;
            go_sync <= 1'b0;
            go_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking, so each flop captures its predecessor's pre-edge value.
            go_meta <= go;
            go_sync <= go_meta;
            go_prev <= go_sync;
        end
    end

    assign go_pulse = go_sync & ~go_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        next_state = state;
        retire     = 1'b0;
        latch_sys  = 1'b0;
        case (state)
            S_RUN: begin
                if (syscall) begin
                    if (v0 == HALT_CODE) begin
                        next_state = S_HALT;
                    end else begin
                        next_state = S_PAUSE;
                        latch_sys  = 1'b1;
                    end
                end else begin
                    retire = 1'b1;
                    if (step_mode) begin
                        next_state = S_STEP_WAIT;
                    end
                end
            end
            S_PAUSE, S_STEP_WAIT: begin
                if (go_pulse) begin
                    next_state = S_RESUME;
                end
            end
            // RESUME ignores syscall, so the syscall that caused the pause retires exactly once.
            S_RESUME: begin
                retire     = 1'b1;
                next_state = step_mode ? S_STEP_WAIT : S_RUN;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_RUN;
            end
        endcase
    end

    // The PC stays enabled during reset, even if a syscall is presented at that time.
    assign pc_enable = retire | ~rst;
    assign halted    = (state == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sys_reg   <= '0;
            cycle_cnt <= '0;
            jmp_cnt   <= '0;
            br_cnt    <= '0;
        end else begin
            if (latch_sys) begin
                sys_reg <= a0;
            end
            if (retire) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                if (jmp_taken) begin
                    jmp_cnt <= jmp_cnt + 16'd1;
                end
                if (br_taken) begin
                    br_cnt <= br_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_data <= '0;
        end else begin
            case (disp_sel)
                2'd0:    disp_data <= sys_reg;
                2'd1:    disp_data <= cycle_cnt;
                2'd2:    disp_data <= {jmp_cnt, br_cnt};
                default: disp_data <= {29'b0, state};
            endcase
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed scenarios followed by random stimulus. All results are
// checked against a behavioural model built from the controller's documented rules.
module tb_exec_ctrl;

    localparam logic [31:0] HALT = 32'd10;
    localparam int M_RUN = 0, M_PAUSE = 1, M_STEP_WAIT = 2, M_RESUME = 3, M_HALT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic        step_mode = 1'b0;
    logic        syscall = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        jmp_taken = 1'b0;
    logic        br_taken = 1'b0;
    logic [1:0]  disp_sel = '0;
    logic        pc_enable;
    logic        halted;
    logic [31:0] disp_data;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state.
    int          m_state;
    logic [31:0] m_sys;
    logic [31:0] m_cyc;
    logic [15:0] m_jmp;
    logic [15:0] m_br;
    logic [31:0] m_disp;
    bit          go_hist[$];   // go samples at past edges, most recent first

    exec_ctrl #(.HALT_CODE(HALT)) dut (
        .clk(clk), .rst(rst), .go(go), .step_mode(step_mode), .syscall(syscall),
        .v0(v0), .a0(a0), .jmp_taken(jmp_taken), .br_taken(br_taken),
        .disp_sel(disp_sel), .pc_enable(pc_enable), .halted(halted), .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic model_pe();
        return (m_state == M_RUN && !syscall) || (m_state == M_RESUME);
    endfunction

    function automatic void model_reset();
        m_state = M_RUN;
        m_sys   = '0;
        m_cyc   = '0;
        m_jmp   = '0;
        m_br    = '0;
        m_disp  = '0;
        go_hist = '{0, 0, 0, 0};
    endfunction

    // One rising edge. A go press acts at the edge where it was sampled high two edges
    // earlier and low three edges earlier.
    function automatic void model_edge();
        bit   pulse = go_hist[1] && !go_hist[2];
        logic pe = model_pe();
        case (disp_sel)
            2'd0:    m_disp = m_sys;
            2'd1:    m_disp = m_cyc;
            2'd2:    m_disp = {m_jmp, m_br};
            default: m_disp = 32'(m_state);
        endcase
        if (pe) begin
            m_cyc += 1;
            if (jmp_taken) m_jmp += 1;
            if (br_taken)  m_br += 1;
        end
        case (m_state)
            M_RUN: begin
                if (syscall && v0 == HALT) m_state = M_HALT;
                else if (syscall) begin
                    m_state = M_PAUSE;
                    m_sys = a0;
                end else if (step_mode) m_state = M_STEP_WAIT;
            end
            M_PAUSE, M_STEP_WAIT: if (pulse) m_state = M_RESUME;
            M_RESUME: m_state = step_mode ? M_STEP_WAIT : M_RUN;
            default: ;
        endcase
        go_hist.push_front(go);
        void'(go_hist.pop_back());
    endfunction

    // Drive one cycle, check the outputs against the model, then advance the model at the edge.
    // A glitch width of 1..3 stays clear of the edge; a width of 4 or more straddles it.
    task automatic step(input logic g, input logic sm, input logic sc, input logic [31:0] v,
                        input logic [31:0] a, input logic jt, input logic bt,
                        input logic [1:0] sel, input int glitch_w = 0);
        @(negedge clk);
        go = g; step_mode = sm; syscall = sc; v0 = v; a0 = a;
        jmp_taken = jt; br_taken = bt; disp_sel = sel;
        #1;
        check("pc_enable", 32'(pc_enable), 32'(model_pe()));
        check("halted", 32'(halted), 32'(m_state == M_HALT));
        check("disp_data", disp_data, m_disp);
        if (glitch_w > 0 && glitch_w < 4) begin
            go = 1'b1;
            #(glitch_w);
            go = 1'b0;
        end else if (glitch_w >= 4) begin
            go = 1'b1;
            fork
                begin
                    #6;
                    go = 1'b0;
                end
            join_none
        end
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input logic sm, input logic [1:0] sel);
        step(1'b0, sm, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, sel);
    endtask

    task automatic do_reset();
        @(negedge clk);
        go = 1'b0;
        syscall = 1'b1;
        v0 = 32'd1;
        rst = 1'b0;
        #1;
        check("rst_pc_enable", 32'(pc_enable), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_disp_data", disp_data, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        syscall = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();

        // Free run: five retirements, then the cycle count appears on the display.
        do_reset();
        repeat (5) idle(1'b0, 2'd0);
        idle(1'b0, 2'd1);
        #2 check("free_run_cycle_cnt", disp_data, 32'd5);

        // A non-halt syscall pauses and latches a0. A go press then resumes it and it retires once.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'd1, 32'h1234, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b1, 32'd1, 32'h0, 1'b0, 1'b0, 2'd0);
        #2;
        check("pause_sys_reg", disp_data, 32'h1234);
        check("pause_pc_enable", 32'(pc_enable), 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'd1, 32'h0, 1'b0, 1'b0, 2'd3);
        step(1'b0, 1'b0, 1'b1, 32'd1, 32'h0, 1'b0, 1'b0, 2'd3);
        step(1'b0, 1'b0, 1'b1, 32'd1, 32'h0, 1'b0, 1'b0, 2'd3);
        #2 check("resume_pc_enable", 32'(pc_enable), 32'd1);
        idle(1'b0, 2'd3);
        #2 check("resume_state_code", disp_data, 32'd3);
        idle(1'b0, 2'd3);
        #2 check("back_to_run_code", disp_data, 32'd0);

        // A halt syscall is terminal: go toggles are ignored, and only reset exits HALT.
        do_reset();
        step(1'b0, 1'b0, 1'b1, HALT, 32'h0, 1'b0, 1'b0, 2'd3);
        for (int i = 0; i < 100; i++)
            step(1'(i / 3), 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1, 1'b1, 2'd3);
        #2;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_pc_enable", 32'(pc_enable), 32'd0);
        check("halt_state_code", disp_data, 32'd4);
        do_reset();
        idle(1'b0, 2'd3);
        #2;
        check("post_halt_state_code", disp_data, 32'd0);
        check("post_halt_halted", 32'(halted), 32'd0);

        // Single step: three go presses give three more retirements.
        do_reset();
        idle(1'b1, 2'd3);
        for (int p = 0; p < 3; p++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd3);
            repeat (4) idle(1'b1, 2'd3);
        end
        idle(1'b1, 2'd1);
        #2 check("step_cycle_cnt", disp_data, 32'd4);

        // A held go gives one pulse. A glitch clear of the edge gives none; one across the edge gives one.
        do_reset();
        idle(1'b1, 2'd1);
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd1);
        repeat (4) idle(1'b1, 2'd1);
        #2 check("held_go_cycle_cnt", disp_data, 32'd2);
        step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd1, 3);
        repeat (5) idle(1'b1, 2'd1);
        #2 check("narrow_glitch_cycle_cnt", disp_data, 32'd2);
        step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd1, 6);
        repeat (5) idle(1'b1, 2'd1);
        #2 check("wide_glitch_cycle_cnt", disp_data, 32'd3);

        // Counter wrap: 0x10000 jump+branch retirements.
        do_reset();
        for (int i = 0; i < 32'h10000; i++)
            step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 2'd1);
        step(1'b0, 1'b0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0, 2'd2);
        #2 check("wrap_jmp_br", disp_data, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd1);
        #2 check("wrap_cycle_cnt", disp_data, 32'h10000);

        // Random traffic with occasional resets, including resets taken during PAUSE or HALT.
        do_reset();
        begin
            logic       g = 1'b0;
            logic       sm = 1'b0;
            logic       sc;
            logic [31:0] v;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                    g = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) g = ~g;
                if ($urandom_range(0, 19) == 0) sm = ~sm;
                sc = ($urandom_range(0, 7) == 0);
                v = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
                step(g, sm, sc, v, $urandom, 1'($urandom), 1'($urandom), 2'($urandom),
                     ($urandom_range(0, 49) == 0 && !g) ? int'($urandom_range(1, 6)) : 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter HALT_CODE, default 32'd10, syscall service code in $v0 that terminates execution.
REQ-002 clk  input  1  single system clock; every register in the block is clocked on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 go  input  1  raw, asynchronous continue/step button, active-high.
REQ-005 step_mode  input  1  1 = single-step execution; 0 = free run.
REQ-006 syscall  input  1  decoded syscall for the current instruction.
REQ-007 v0  input  32  register $v0 value for the current instruction.
REQ-008 a0  input  32  register $a0 value for the current instruction.
REQ-009 jmp_taken  input  1  current instruction is j/jal/jr.
REQ-010 br_taken  input  1  current instruction is a taken branch.
REQ-011 disp_sel  input  2  display source select.
REQ-012 pc_enable  output  1  PC register write enable; 1 = current instruction retires.
REQ-013 halted  output  1  1 while in HALT.
REQ-014 disp_data  output  32  registered display word.

Function
REQ-015 The block SHALL be an FSM with states RUN, PAUSE, STEP_WAIT, RESUME and HALT; pc_enable = 1 only in RUN and RESUME.
REQ-016 go SHALL pass a 2-flop synchronizer, then a rising-edge detector; go_pulse is 1 for exactly one cycle per synchronized 0->1 transition.
REQ-017 go_pulse SHALL be high in the 3rd cycle after go rises; the FSM acts at the end of that cycle.
REQ-018 RUN with syscall=1 and v0==HALT_CODE -> HALT, and that instruction SHALL not retire (pc_enable is 0 that cycle).
REQ-019 RUN with syscall=1 and v0!=HALT_CODE -> PAUSE, with pc_enable 0 that cycle, and a0 latched into sys_reg at that edge.
REQ-020 RUN with syscall=0 and step_mode=1 -> STEP_WAIT after the instruction retires.
REQ-021 RUN with syscall=0 and step_mode=0 -> stay in RUN.
REQ-022 PAUSE or STEP_WAIT with go_pulse -> RESUME; otherwise hold; pc_enable stays 0.
REQ-023 RESUME SHALL last exactly one cycle with pc_enable=1 and syscall ignored, so a paused syscall retires once.
REQ-024 RESUME exits to STEP_WAIT when step_mode=1, else to RUN.
REQ-025 HALT SHALL be terminal, exited only by reset; go_pulse is ignored.
REQ-026 step_mode changes SHALL take effect at the next RUN or RESUME decision and SHALL never force a transition out of PAUSE.
REQ-027 cycle_cnt (32b), jmp_cnt (16b) and br_cnt (16b) SHALL wrap modulo 2^width.
REQ-028 cycle_cnt SHALL increment when pc_enable=1; jmp_cnt when pc_enable & jmp_taken; br_cnt when pc_enable & br_taken.
REQ-029 disp_data SHALL be registered, one-cycle latency: sel 0 = sys_reg; sel 1 = cycle_cnt; sel 2 = {jmp_cnt, br_cnt}; sel 3 = {29'b0, state code}.
REQ-030 State codes SHALL be RUN=0, PAUSE=1, STEP_WAIT=2, RESUME=3, HALT=4.
REQ-031 A go_pulse in RUN, RESUME or HALT SHALL be discarded (not queued).

Reset
REQ-032 While rst=0, the block SHALL immediately force state=RUN, pc_enable=1, halted=0, disp_data=0, sys_reg=0, all counters=0 and sync/edge flops=0.
REQ-033 Reset asserted mid-PAUSE or in HALT SHALL return the block to RUN with no pending go_pulse.
REQ-034 On the first clk edge after rst rises, the first instruction SHALL retire.

Verification
REQ-035 Free run, step_mode=0, 5 cycles, no syscall -> pc_enable=1 throughout; disp_sel=1 gives disp_data=5 one cycle later.
REQ-036 syscall, v0=1, a0=0x1234 -> PAUSE, pc_enable=0 and sel 0 gives 0x1234; go pulse -> one RESUME cycle with syscall still high and pc_enable=1, then RUN.
REQ-037 syscall, v0=10 -> halted=1 and pc_enable=0 held for 100 cycles despite go toggles; rst=0 -> RUN.
REQ-038 step_mode=1, 3 go pulses -> exactly 3 retirements (cycle_cnt=4 including the first) with state alternating STEP_WAIT/RESUME.
REQ-039 jmp_taken and br_taken high together for 0x10000 retirements -> jmp_cnt=br_cnt=0 (wrap) and cycle_cnt=0x10000.
REQ-040 go held high continuously -> exactly one go_pulse; a go glitch shorter than one clk period -> at most one pulse.
